life_gen_scheduler: RTL and testbench

Owns the PE array command bus (x, y, cmd, val). It arbitrates among three sources: host cell writes, full-array clear sweeps, and generation PROCESS commands. PROCESS commands come from single-step requests or a programmable run-mode timer. It sits between the host/pattern-loading logic and the PE array, and supersedes ad-hoc hardwired loaders.

---
 rtl/life_gen_scheduler_if.sv | 32 +++
 rtl/life_gen_scheduler.sv | 147 ++++++++++++++
 tb/tb_life_gen_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/life_gen_scheduler_if.sv
// life_gen_scheduler_if: host write, request and PE array command bundle for the generation scheduler
interface life_gen_scheduler_if #(
  parameter int PX_BITS    = 4,
  parameter int PY_BITS    = 4,
  parameter int STATE_BITS = 1,
  parameter int CMD_BITS   = 2,
  parameter int GEN_BITS   = 16
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [PX_BITS-1:0]    wr_x;
  logic [PY_BITS-1:0]    wr_y;
  logic [STATE_BITS-1:0] wr_val;
  logic                  clear_req;
  logic                  step_req;
  logic                  run;
  logic [15:0]           period;
  logic [PX_BITS-1:0]    x;
  logic [PY_BITS-1:0]    y;
  logic [CMD_BITS-1:0]   cmd;
  logic [STATE_BITS-1:0] val;
  logic                  busy;
  logic [GEN_BITS-1:0]   gen_count;
  modport master (
    input  wr_valid, wr_x, wr_y, wr_val, clear_req, step_req, run, period,
    output wr_ready, x, y, cmd, val, busy, gen_count
  );
  modport slave (
    output wr_valid, wr_x, wr_y, wr_val, clear_req, step_req, run, period,
    input  wr_ready, x, y, cmd, val, busy, gen_count
  );
endinterface

// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler: arbitrates host writes, clear sweeps and PROCESS steps onto the PE array command bus
module life_gen_scheduler #(
  parameter int X_SIZE     = 16,
  parameter int Y_SIZE     = 16,
  parameter int SETTLE     = 1,
  parameter int GEN_BITS   = 16,
  parameter int PX_BITS    = 4,
  parameter int PY_BITS    = 4,
  parameter int STATE_BITS = 1
) (
  input logic                   clk,
  input logic                   reset,
  life_gen_scheduler_if.master  bus
);
  localparam logic [1:0] CMD_NOP     = 2'd0;
  localparam logic [1:0] CMD_WRITE   = 2'd1;
  localparam logic [1:0] CMD_PROCESS = 2'd2;
  localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SLAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [PX_BITS-1:0] X_LAST = PX_BITS'(X_SIZE - 1);
  localparam logic [PY_BITS-1:0] Y_LAST = PY_BITS'(Y_SIZE - 1);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PROC, S_SETTLE} state_e;
  state_e                state_q, state_d;
  logic                  clear_pend_q, clear_pend_d;
  logic                  step_pend_q, step_pend_d;
  logic [15:0]           timer_q, timer_d;
  logic [PX_BITS-1:0]    sx_q, sx_d;
  logic [PY_BITS-1:0]    sy_q, sy_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [GEN_BITS-1:0]   gen_q, gen_d;
  logic [PX_BITS-1:0]    x_q, x_d;
  logic [PY_BITS-1:0]    y_q, y_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [STATE_BITS-1:0] val_q, val_d;
  logic                  busy_q, busy_d;
  logic [15:0]           per_m1;
  logic                  tick;
  logic                  wr_fire;
  logic                  sweep_last;
  assign per_m1         = (bus.period == 16'd0) ? 16'd0 : bus.period - 16'd1;
  assign bus.wr_ready   = (state_q == S_IDLE) && !clear_pend_q && !step_pend_q;
  assign wr_fire        = bus.wr_valid && bus.wr_ready;
  assign sweep_last     = (sx_q == X_LAST) && (sy_q == Y_LAST);
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.cmd        = cmd_q;
  assign bus.val        = val_q;
  assign bus.busy       = busy_q;
  assign bus.gen_count  = gen_q;
  // The timer keeps counting through PROC/SETTLE so run-mode spacing stays exact.
  always_comb begin
    tick    = bus.run && (state_q != S_CLEAR) && (timer_q >= per_m1);
    timer_d = !bus.run ? 16'd0 : (state_q == S_CLEAR) ? timer_q : tick ? 16'd0 : timer_q + 16'd1;
  end
  // Outputs are computed for the state being entered, so they register alongside it.
  always_comb begin
    state_d      = state_q;
    clear_pend_d = clear_pend_q | bus.clear_req;
    step_pend_d  = step_pend_q | bus.step_req | tick;
    sx_d         = sx_q;
    sy_d         = sy_q;
    settle_d     = settle_q;
    gen_d        = gen_q;
    x_d          = '0;
    y_d          = '0;
    cmd_d        = CMD_NOP;
    val_d        = '0;
    busy_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_pend_q) begin
          state_d      = S_CLEAR;
          clear_pend_d = bus.clear_req;
          sx_d         = '0;
          sy_d         = '0;
          cmd_d        = CMD_WRITE;
          busy_d       = 1'b1;
        end else if (step_pend_q) begin
          state_d     = S_PROC;
          step_pend_d = bus.step_req | tick;
          cmd_d       = CMD_PROCESS;
          gen_d       = gen_q + GEN_BITS'(1);
          busy_d      = 1'b1;
        end else if (wr_fire) begin
          cmd_d = CMD_WRITE;
          x_d   = bus.wr_x;
          y_d   = bus.wr_y;
          val_d = bus.wr_val;
        end
      end
      S_CLEAR: begin
        if (sweep_last) begin
          state_d = S_IDLE;
          gen_d   = '0;
        end else begin
          sx_d   = (sx_q == X_LAST) ? '0 : sx_q + PX_BITS'(1);
          sy_d   = (sx_q == X_LAST) ? sy_q + PY_BITS'(1) : sy_q;
          x_d    = sx_d;
          y_d    = sy_d;
          cmd_d  = CMD_WRITE;
          busy_d = 1'b1;
        end
      end
      S_PROC: begin
        state_d  = (SETTLE != 0) ? S_SETTLE : S_IDLE;
        settle_d = '0;
        busy_d   = (SETTLE != 0);
      end
      default: begin
        state_d  = (settle_q == SW'(SLAST)) ? S_IDLE : S_SETTLE;
        settle_d = settle_q + SW'(1);
        busy_d   = (settle_q != SW'(SLAST));
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clear_pend_q <= 1'b0;
      step_pend_q  <= 1'b0;
      timer_q      <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      settle_q     <= '0;
      gen_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cmd_q        <= CMD_NOP;
      val_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_pend_q <= clear_pend_d;
      step_pend_q  <= step_pend_d;
      timer_q      <= timer_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      settle_q     <= settle_d;
      gen_q        <= gen_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cmd_q        <= cmd_d;
      val_q        <= val_d;
      busy_q       <= busy_d;
    end
  end
endmodule

// File: tb/tb_life_gen_scheduler.sv
// tb_life_gen_scheduler: directed checks of host writes, clear sweep, stepping, run mode, collisions and reset
module tb_life_gen_scheduler;
  localparam logic [1:0] CMD_N = 2'd0;
  localparam logic [1:0] CMD_W = 2'd1;
  localparam logic [1:0] CMD_P = 2'd2;
  typedef struct {
    logic       wv;
    logic [3:0] wx;
    logic [3:0] wy;
    logic       wval;
    logic       rdy;
    logic [1:0] cmd;
    logic [3:0] x;
    logic [3:0] y;
    logic       v;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t vecs[7];
  always #5 clk = ~clk;
  life_gen_scheduler_if #(.PX_BITS(4), .PY_BITS(4), .STATE_BITS(1), .CMD_BITS(2), .GEN_BITS(16)) bus ();
  life_gen_scheduler #(
    .X_SIZE(4), .Y_SIZE(4), .SETTLE(2), .GEN_BITS(16),
    .PX_BITS(4), .PY_BITS(4), .STATE_BITS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [1:0] c, input logic [3:0] ex, input logic [3:0] ey,
                         input logic ev, input logic eb);
    chk({tag, ".cmd"}, 32'(bus.cmd), 32'(c));
    chk({tag, ".x"}, 32'(bus.x), 32'(ex));
    chk({tag, ".y"}, 32'(bus.y), 32'(ey));
    chk({tag, ".val"}, 32'(bus.val), 32'(ev));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int clr_cnt, proc_seen, gen_at_proc, early_ready, bad;
    logic acc;
    vecs[0] = '{1'b1, 4'd5, 4'd5, 1'b1, 1'b1, CMD_W, 4'd5, 4'd5, 1'b1};
    vecs[1] = '{1'b1, 4'd5, 4'd6, 1'b1, 1'b1, CMD_W, 4'd5, 4'd6, 1'b1};
    vecs[2] = '{1'b1, 4'd6, 4'd5, 1'b1, 1'b1, CMD_W, 4'd6, 4'd5, 1'b1};
    vecs[3] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, CMD_N, 4'd0, 4'd0, 1'b0};
    vecs[4] = '{1'b1, 4'd15, 4'd15, 1'b1, 1'b1, CMD_W, 4'd15, 4'd15, 1'b1};
    vecs[5] = '{1'b1, 4'd3, 4'd0, 1'b0, 1'b1, CMD_W, 4'd3, 4'd0, 1'b0};
    vecs[6] = '{1'b0, 4'd9, 4'd9, 1'b1, 1'b1, CMD_N, 4'd0, 4'd0, 1'b0};
    bus.wr_valid = 1'b0;
    bus.wr_x = '0;
    bus.wr_y = '0;
    bus.wr_val = '0;
    bus.clear_req = 1'b0;
    bus.step_req = 1'b0;
    bus.run = 1'b0;
    bus.period = 16'd5;
    #2 reset = 1'b1;
    #1 chk_out("reset_async", CMD_N, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("reset_async.gen", 32'(bus.gen_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_out("reset_held", CMD_N, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("reset_held.ready", 32'(bus.wr_ready), 32'd1);
    for (int i = 0; i < 7; i++) begin
      bus.wr_valid = vecs[i].wv;
      bus.wr_x = vecs[i].wx;
      bus.wr_y = vecs[i].wy;
      bus.wr_val = vecs[i].wval;
      chk($sformatf("host%0d.ready", i), 32'(bus.wr_ready), 32'(vecs[i].rdy));
      cyc();
      chk_out($sformatf("host%0d", i), vecs[i].cmd, vecs[i].x, vecs[i].y, vecs[i].v, 1'b0);
      chk($sformatf("host%0d.gen", i), 32'(bus.gen_count), 32'd0);
    end
    bus.wr_valid = 1'b0;
    bus.clear_req = 1'b1;
    cyc();
    bus.clear_req = 1'b0;
    chk_out("clear.pend", CMD_N, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("clear.pend.ready", 32'(bus.wr_ready), 32'd0);
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("clear%0d", i), CMD_W, 4'(i % 4), 4'(i / 4), 1'b0, 1'b1);
      chk($sformatf("clear%0d.ready", i), 32'(bus.wr_ready), 32'd0);
      cyc();
    end
    chk_out("clear.done", CMD_N, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("clear.done.ready", 32'(bus.wr_ready), 32'd1);
    bus.step_req = 1'b1;
    cyc();
    bus.step_req = 1'b0;
    chk("step.pend.ready", 32'(bus.wr_ready), 32'd0);
    cyc();
    chk_out("step.proc", CMD_P, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("step.proc.gen", 32'(bus.gen_count), 32'd1);
    chk("step.proc.ready", 32'(bus.wr_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk_out($sformatf("step.settle%0d", i), CMD_N, 4'd0, 4'd0, 1'b0, 1'b1);
      chk($sformatf("step.settle%0d.ready", i), 32'(bus.wr_ready), 32'd0);
    end
    cyc();
    chk("step.idle.busy", 32'(bus.busy), 32'd0);
    chk("step.idle.ready", 32'(bus.wr_ready), 32'd1);
    chk("step.idle.gen", 32'(bus.gen_count), 32'd1);
    bus.period = 16'd5;
    bus.run = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      cyc();
      chk($sformatf("run5.c%0d", c), 32'(bus.cmd), (c >= 6 && (c - 6) % 5 == 0) ? 32'(CMD_P) : 32'(CMD_N));
    end
    bus.run = 1'b0;
    repeat (4) cyc();
    chk("run5.gen", 32'(bus.gen_count), 32'd6);
    chk("run5.busy", 32'(bus.busy), 32'd0);
    bus.period = 16'd0;
    bus.run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk($sformatf("run0.c%0d", c), 32'(bus.cmd), (c >= 2 && (c - 2) % 4 == 0) ? 32'(CMD_P) : 32'(CMD_N));
    end
    bus.run = 1'b0;
    repeat (6) cyc();
    chk("run0.gen", 32'(bus.gen_count), 32'd10);
    chk("run0.busy", 32'(bus.busy), 32'd0);
    bus.step_req = 1'b1;
    cyc();
    bus.step_req = 1'b0;
    cyc();
    chk("coll.pre.cmd", 32'(bus.cmd), 32'(CMD_P));
    bus.clear_req = 1'b1;
    bus.step_req = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_x = 4'd7;
    bus.wr_y = 4'd2;
    bus.wr_val = 1'b1;
    chk("coll.ready0", 32'(bus.wr_ready), 32'd0);
    cyc();
    bus.clear_req = 1'b0;
    bus.step_req = 1'b0;
    clr_cnt = 0;
    proc_seen = 0;
    gen_at_proc = -1;
    early_ready = 0;
    acc = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus.wr_ready) begin
        if (clr_cnt != 16 || proc_seen != 1) early_ready++;
        acc = 1'b1;
      end
      cyc();
      if (acc) begin
        bus.wr_valid = 1'b0;
        chk_out("coll.write", CMD_W, 4'd7, 4'd2, 1'b1, 1'b0);
        break;
      end
      if (bus.cmd == CMD_W && bus.val == 1'b0 && proc_seen == 0) clr_cnt++;
      if (bus.cmd == CMD_P) begin
        proc_seen++;
        gen_at_proc = int'(bus.gen_count);
      end
    end
    bus.wr_valid = 1'b0;
    chk("coll.accepted", 32'(acc), 32'd1);
    chk("coll.clear_writes", 32'(clr_cnt), 32'd16);
    chk("coll.procs", 32'(proc_seen), 32'd1);
    chk("coll.gen_at_proc", 32'(gen_at_proc), 32'd1);
    chk("coll.early_ready", 32'(early_ready), 32'd0);
    cyc();
    bus.clear_req = 1'b1;
    cyc();
    bus.clear_req = 1'b0;
    cyc();
    repeat (7) cyc();
    chk_out("rstclr.idx7", CMD_W, 4'd3, 4'd1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 chk_out("rstclr.async", CMD_N, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("rstclr.gen", 32'(bus.gen_count), 32'd0);
    cyc();
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (bus.cmd !== CMD_N || bus.busy !== 1'b0) bad++;
    end
    chk("rstclr.no_residual", 32'(bad), 32'd0);
    chk("rstclr.ready", 32'(bus.wr_ready), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
